// File: rtl/ooo_config_pkg.sv
// Shared out-of-order core configuration: widths, the reservation entry and helpers.
package ooo_config_pkg;

    localparam int unsigned BR_TAGS   = 4;
    localparam int unsigned BRU_BITS  = $clog2(BR_TAGS);
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned PREG_W    = 6;
    localparam int unsigned UOP_W     = 32;

    typedef struct packed {
        logic [PREG_W-1:0]    pd;
        logic [PREG_W-1:0]    ps1;
        logic [PREG_W-1:0]    ps2;
        logic                 imm_optional;
        logic [UOP_W-1:0]     uop;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [BR_TAGS-1:0]   branch_mask;
        logic [BRU_BITS-1:0]  br_tag;
        logic                 is_branch;
    } resv_entry_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [BRU_BITS-1:0] pick_lowest(input logic [BR_TAGS-1:0] v);
        pick_lowest = '0;
        for (int i = int'(BR_TAGS) - 1; i >= 0; i--) begin
            if (v[i]) pick_lowest = BRU_BITS'(i);
        end
    endfunction

endpackage

// File: rtl/dispatch_stage_br_tag_alloc.sv
// Branch-tag bookkeeping: free list, speculative mask and per-tag mask snapshots.
module br_tag_alloc
    import ooo_config_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc,
    input  logic                good,
    input  logic                flush,
    input  logic [BRU_BITS-1:0] br_idx,
    output logic                tag_avail_c,
    output logic [BRU_BITS-1:0] alloc_tag_c,
    output logic [BR_TAGS-1:0]  mask_fwd_c
);

    logic [BR_TAGS-1:0] cur_mask;
    logic [BR_TAGS-1:0] tag_free;
    logic [BR_TAGS-1:0] snap [BR_TAGS];
    logic [BR_TAGS-1:0] cur_mask_n;
    logic [BR_TAGS-1:0] tag_free_n;
    logic [BR_TAGS-1:0] snap_n [BR_TAGS];
    logic [BR_TAGS-1:0] good_bit;

    // Picks from the registered free list, so a tag freed this cycle waits a cycle.
    always_comb begin
        good_bit         = '0;
        good_bit[br_idx] = good;
        mask_fwd_c       = cur_mask & ~good_bit;
        tag_avail_c      = |tag_free;
        alloc_tag_c      = pick_lowest(tag_free);
        cur_mask_n       = mask_fwd_c;
        tag_free_n       = tag_free | good_bit;
        for (int t = 0; t < int'(BR_TAGS); t++) begin
            snap_n[t] = snap[t] & ~good_bit;
        end
        if (flush) begin
            cur_mask_n = snap[br_idx];
            tag_free_n = tag_free | (cur_mask & ~snap[br_idx]);
        end
        if (alloc) begin
            tag_free_n[alloc_tag_c] = 1'b0;
            snap_n[alloc_tag_c]     = mask_fwd_c;
            cur_mask_n[alloc_tag_c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mask <= '0;
            tag_free <= '1;
            for (int t = 0; t < int'(BR_TAGS); t++) snap[t] <= '0;
        end else begin
            cur_mask <= cur_mask_n;
            tag_free <= tag_free_n;
            for (int t = 0; t < int'(BR_TAGS); t++) snap[t] <= snap_n[t];
        end
    end

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: ROB/branch-tag allocation and a single entry register toward the reservation station.
module dispatch_stage
    import ooo_config_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PREG_W-1:0]    in_pd,
    input  logic [PREG_W-1:0]    in_ps1,
    input  logic [PREG_W-1:0]    in_ps2,
    input  logic                 in_imm_optional,
    input  logic                 in_is_branch,
    input  logic [UOP_W-1:0]     in_uop,
    input  logic                 rob_ready,
    output logic                 rob_alloc,
    input  logic [ROB_IDX_W-1:0] rob_idx,
    input  logic                 resv_full,
    output logic                 out_valid,
    output logic [PREG_W-1:0]    out_pd,
    output logic [PREG_W-1:0]    out_ps1,
    output logic [PREG_W-1:0]    out_ps2,
    output logic                 out_imm_optional,
    output logic [UOP_W-1:0]     out_uop,
    output logic [ROB_IDX_W-1:0] out_rob_idx,
    output logic [BR_TAGS-1:0]   out_branch_mask,
    output logic [BRU_BITS-1:0]  out_br_tag,
    output logic                 out_is_branch,
    input  logic                 br_valid,
    input  logic                 br_mispred,
    input  logic [BRU_BITS-1:0]  br_idx
);

    logic                flush_c;
    logic                good_c;
    logic                accept_c;
    logic                kill_c;
    logic                tag_avail_c;
    logic [BRU_BITS-1:0] alloc_tag_c;
    logic [BR_TAGS-1:0]  mask_fwd_c;
    logic [BR_TAGS-1:0]  good_bit_c;
    resv_entry_t         entry_d;
    resv_entry_t         entry_q;

    br_tag_alloc u_tags (
        .clk         (clk),
        .rst         (rst),
        .alloc       (accept_c & in_is_branch),
        .good        (good_c),
        .flush       (flush_c),
        .br_idx      (br_idx),
        .tag_avail_c (tag_avail_c),
        .alloc_tag_c (alloc_tag_c),
        .mask_fwd_c  (mask_fwd_c)
    );

    always_comb begin
        flush_c            = br_valid & br_mispred;
        good_c             = br_valid & ~br_mispred;
        good_bit_c         = '0;
        good_bit_c[br_idx] = good_c;
        in_ready           = rob_ready & (~in_is_branch | tag_avail_c)
                           & (~out_valid | ~resv_full) & ~flush_c;
        accept_c           = in_valid & in_ready;
        rob_alloc          = accept_c;
        // Held op dies if it depends on, or is, the mispredicted branch.
        kill_c             = entry_q.branch_mask[br_idx]
                           | (entry_q.is_branch & (entry_q.br_tag == br_idx));
        entry_d            = '{pd: in_pd, ps1: in_ps1, ps2: in_ps2,
                               imm_optional: in_imm_optional, uop: in_uop,
                               rob_idx: rob_idx, branch_mask: mask_fwd_c,
                               br_tag: alloc_tag_c, is_branch: in_is_branch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            entry_q   <= '0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
            entry_q   <= entry_d;
        end else begin
            if (out_valid && !resv_full) out_valid <= 1'b0;
            if (flush_c && kill_c)       out_valid <= 1'b0;
            entry_q.branch_mask <= entry_q.branch_mask & ~good_bit_c;
        end
    end

    assign out_pd           = entry_q.pd;
    assign out_ps1          = entry_q.ps1;
    assign out_ps2          = entry_q.ps2;
    assign out_imm_optional = entry_q.imm_optional;
    assign out_uop          = entry_q.uop;
    assign out_rob_idx      = entry_q.rob_idx;
    assign out_branch_mask  = entry_q.branch_mask;
    assign out_br_tag       = entry_q.br_tag;
    assign out_is_branch    = entry_q.is_branch;

endmodule

// File: tb/tb_dispatch_stage.sv
// Directed self-checking bench for dispatch_stage.
module tb_dispatch_stage;
    import ooo_config_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [PREG_W-1:0]    in_pd = '0, in_ps1 = '0, in_ps2 = '0;
    logic                 in_imm_optional = 1'b0;
    logic                 in_is_branch = 1'b0;
    logic [UOP_W-1:0]     in_uop = '0;
    logic                 rob_ready = 1'b1;
    logic                 rob_alloc;
    logic [ROB_IDX_W-1:0] rob_idx = '0;
    logic                 resv_full = 1'b0;
    logic                 out_valid;
    logic [PREG_W-1:0]    out_pd, out_ps1, out_ps2;
    logic                 out_imm_optional;
    logic [UOP_W-1:0]     out_uop;
    logic [ROB_IDX_W-1:0] out_rob_idx;
    logic [BR_TAGS-1:0]   out_branch_mask;
    logic [BRU_BITS-1:0]  out_br_tag;
    logic                 out_is_branch;
    logic                 br_valid = 1'b0;
    logic                 br_mispred = 1'b0;
    logic [BRU_BITS-1:0]  br_idx = '0;

    int n_vec = 0;
    int n_bad = 0;
    int alloc_cnt = 0;

    dispatch_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pd(in_pd), .in_ps1(in_ps1), .in_ps2(in_ps2),
        .in_imm_optional(in_imm_optional), .in_is_branch(in_is_branch), .in_uop(in_uop),
        .rob_ready(rob_ready), .rob_alloc(rob_alloc), .rob_idx(rob_idx),
        .resv_full(resv_full), .out_valid(out_valid),
        .out_pd(out_pd), .out_ps1(out_ps1), .out_ps2(out_ps2),
        .out_imm_optional(out_imm_optional), .out_uop(out_uop),
        .out_rob_idx(out_rob_idx), .out_branch_mask(out_branch_mask),
        .out_br_tag(out_br_tag), .out_is_branch(out_is_branch),
        .br_valid(br_valid), .br_mispred(br_mispred), .br_idx(br_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rob_alloc) alloc_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; br_valid = 1'b0; resv_full = 1'b0; rob_ready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    // Presents one op for a cycle and checks whether it is taken.
    task automatic issue(input string tag, input logic br, input logic [31:0] uop,
                         input logic [3:0] ridx, input logic exp_acc);
        in_valid = 1'b1; in_is_branch = br; in_uop = uop; rob_idx = ridx;
        in_pd = 6'(uop); in_ps1 = 6'(uop >> 8); in_ps2 = 6'(uop >> 16);
        in_imm_optional = uop[0];
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_acc));
        check({tag, ".rob_alloc"}, 64'(rob_alloc), 64'(exp_acc));
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        do_reset();
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.rob_alloc", 64'(rob_alloc), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.cur_mask", 64'(dut.u_tags.cur_mask), 64'h0);
        check("rst.tag_free", 64'(dut.u_tags.tag_free), 64'hf);

        // Three back-to-back non-branch ops
        alloc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            issue("nb", 1'b0, 32'h0001_0203 + 32'(i), 4'(i + 1), 1'b1);
            check("nb.out_valid", 64'(out_valid), 64'd1);
            check("nb.out_uop", 64'(out_uop), 64'h0001_0203 + 64'(i));
            check("nb.out_rob_idx", 64'(out_rob_idx), 64'(i + 1));
            check("nb.out_mask", 64'(out_branch_mask), 64'h0);
        end
        check("nb.out_pd", 64'(out_pd), 64'h05);
        check("nb.out_ps1", 64'(out_ps1), 64'h02);
        check("nb.out_ps2", 64'(out_ps2), 64'h01);
        check("nb.out_imm", 64'(out_imm_optional), 64'd1);
        step();
        check("nb.drain", 64'(out_valid), 64'd0);
        check("nb.alloc_cnt", 64'(alloc_cnt), 64'd3);

        // Exhaust the tags, then free tag 1 with a good resolve
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue("br4", 1'b1, 32'hB000 + 32'(i), 4'(i), 1'b1);
            check("br4.tag", 64'(out_br_tag), 64'(i));
            check("br4.is_branch", 64'(out_is_branch), 64'd1);
            check("br4.mask", 64'(out_branch_mask), (64'd1 << i) - 64'd1);
        end
        in_valid = 1'b1; in_is_branch = 1'b1; #1;
        check("br5.stall_ready", 64'(in_ready), 64'd0);
        check("br5.stall_alloc", 64'(rob_alloc), 64'd0);
        step();
        issue("notag_nb", 1'b0, 32'hC0DE, 4'd5, 1'b1);
        check("notag_nb.mask", 64'(out_branch_mask), 64'hf);
        in_valid = 1'b1; in_is_branch = 1'b1;
        br_valid = 1'b1; br_mispred = 1'b0; br_idx = 2'd1; #1;
        check("br5.same_cycle_free", 64'(in_ready), 64'd0);
        step();
        br_valid = 1'b0;
        issue("br5", 1'b1, 32'hB005, 4'd6, 1'b1);
        check("br5.tag", 64'(out_br_tag), 64'd1);
        check("br5.mask", 64'(out_branch_mask), 64'hd);

        // Mispredict on tag 0 kills a held dependent load
        do_reset();
        issue("mp.b0", 1'b1, 32'hA0, 4'd0, 1'b1);
        issue("mp.b1", 1'b1, 32'hA1, 4'd1, 1'b1);
        issue("mp.ld", 1'b0, 32'hA2, 4'd2, 1'b1);
        check("mp.ld_mask", 64'(out_branch_mask), 64'h3);
        resv_full = 1'b1;
        step();
        check("mp.held", 64'(out_valid), 64'd1);
        br_valid = 1'b1; br_mispred = 1'b1; br_idx = 2'd0; #1;
        check("mp.flush_ready", 64'(in_ready), 64'd0);
        step();
        br_valid = 1'b0; resv_full = 1'b0;
        check("mp.dropped", 64'(out_valid), 64'd0);
        check("mp.cur_mask", 64'(dut.u_tags.cur_mask), 64'h0);
        check("mp.tag_free", 64'(dut.u_tags.tag_free), 64'hf);

        // Good resolve clears the mask bit of a held entry
        do_reset();
        for (int i = 0; i < 3; i++) issue("gd.br", 1'b1, 32'hD0 + 32'(i), 4'(i), 1'b1);
        issue("gd.ld", 1'b0, 32'hD3, 4'd3, 1'b1);
        check("gd.ld_mask", 64'(out_branch_mask), 64'h7);
        resv_full = 1'b1; #1;
        check("gd.full_ready", 64'(in_ready), 64'd0);
        step();
        br_valid = 1'b1; br_mispred = 1'b0; br_idx = 2'd2;
        step();
        br_valid = 1'b0;
        check("gd.held", 64'(out_valid), 64'd1);
        check("gd.held_mask", 64'(out_branch_mask), 64'h3);
        check("gd.held_uop", 64'(out_uop), 64'hD3);
        check("gd.tag_free", 64'(dut.u_tags.tag_free), 64'hc);
        resv_full = 1'b0;
        step();
        check("gd.drain", 64'(out_valid), 64'd0);

        // Reset while an entry is stalled
        issue("rs.op", 1'b0, 32'hE1, 4'd7, 1'b1);
        resv_full = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; resv_full = 1'b0;
        check("rs.discard", 64'(out_valid), 64'd0);

        // ROB not ready: nothing accepted, entry untouched
        issue("rr.op", 1'b0, 32'hF1, 4'd8, 1'b1);
        step();
        rob_ready = 1'b0; in_valid = 1'b1; in_is_branch = 1'b0; in_uop = 32'hF2; #1;
        check("rr.in_ready", 64'(in_ready), 64'd0);
        check("rr.rob_alloc", 64'(rob_alloc), 64'd0);
        step();
        in_valid = 1'b0; rob_ready = 1'b1;
        check("rr.out_valid", 64'(out_valid), 64'd0);
        check("rr.out_uop", 64'(out_uop), 64'hF1);

        // Op arriving with a mispredict waits, then takes the restored mask
        do_reset();
        issue("fx.b0", 1'b1, 32'h10, 4'd0, 1'b1);
        issue("fx.b1", 1'b1, 32'h11, 4'd1, 1'b1);
        step();
        br_valid = 1'b1; br_mispred = 1'b1; br_idx = 2'd1;
        in_valid = 1'b1; in_is_branch = 1'b0; #1;
        check("fx.ready", 64'(in_ready), 64'd0);
        check("fx.alloc", 64'(rob_alloc), 64'd0);
        step();
        br_valid = 1'b0; br_mispred = 1'b0;
        check("fx.cur_mask", 64'(dut.u_tags.cur_mask), 64'h1);
        check("fx.tag_free", 64'(dut.u_tags.tag_free), 64'he);
        issue("fx.ld", 1'b0, 32'h12, 4'd2, 1'b1);
        check("fx.ld_mask", 64'(out_branch_mask), 64'h1);

        // Accept coincident with a good resolve sees the bit already cleared
        br_valid = 1'b1; br_mispred = 1'b0; br_idx = 2'd0;
        issue("ag.ld", 1'b0, 32'h13, 4'd3, 1'b1);
        br_valid = 1'b0;
        check("ag.mask", 64'(out_branch_mask), 64'h0);
        check("ag.tag_free", 64'(dut.u_tags.tag_free), 64'hf);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dispatch_stage.md
# dispatch_stage

Dispatch stage directly upstream of the reservation station. It accepts one renamed micro-op per cycle and allocates a ROB slot, plus a branch tag for branches. It stamps the op with the current speculative branch mask and holds it in a single output register until the reservation station has room. It owns branch-tag bookkeeping: tags are freed on correct resolve, and the mask is rolled back on mispredict.

## Interface
Parameters:
- BR_TAGS, 4: number of in-flight branch tags; BRU_BITS = $clog2(BR_TAGS).
- ROB_IDX_W, 4: ROB index width.
- PREG_W, 6: physical register index width.
- UOP_W, 32: opaque micro-op payload width, passed through untouched.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  renamed op present.
- in_ready  out  1  op accepted this cycle when in_valid & in_ready.
- in_pd, in_ps1, in_ps2  in  PREG_W  destination and source physical regs.
- in_imm_optional  in  1  ps2 not required.
- in_is_branch  in  1  op needs a branch tag.
- in_uop  in  UOP_W  payload.
- rob_ready  in  1  ROB can allocate.
- rob_alloc  out  1  ROB allocate pulse; equals the accept condition.
- rob_idx  in  ROB_IDX_W  index granted, sampled on rob_alloc.
- resv_full  in  1  reservation station full.
- out_valid  out  1  entry register valid.
- out_pd, out_ps1, out_ps2, out_imm_optional, out_uop  out  as above  latched op.
- out_rob_idx  out  ROB_IDX_W  latched ROB index.
- out_branch_mask  out  BR_TAGS  unresolved branches this op depends on.
- out_br_tag  out  BRU_BITS  own tag; meaningful only when out_is_branch.
- out_is_branch  out  1  latched branch flag.
- br_valid  in  1  branch resolution.
- br_mispred  in  1  qualifies br_valid.
- br_idx  in  BRU_BITS  resolved tag.

## Operation
- State:
  - cur_mask[BR_TAGS]: tags of all unresolved branches dispatched so far.
  - snap[t][BR_TAGS]: cur_mask captured when tag t was allocated, excluding t.
  - tag_free[BR_TAGS].
  - The entry register.
- flush = br_valid & br_mispred; good = br_valid & !br_mispred.
- Tag pick: lowest-index set bit of tag_free.
- tag_avail = |tag_free.
- accept = in_valid & rob_ready & (!in_is_branch | tag_avail) & (!out_valid | !resv_full) & !flush; in_ready equals the same term without in_valid.
- On accept, the entry register loads the input, rob_idx and branch_mask = cur_mask, with good-resolve bit clearing applied.
- On accept of a branch with tag t:
  - tag_free[t] <= 0
  - snap[t] <= cur_mask (good bit cleared)
  - cur_mask[t] <= 1
  - out_br_tag <= t.
- The entry register drains when out_valid & !resv_full & !accept; out_valid <= 0.
- good on tag b:
  - tag_free[b] <= 1
  - cur_mask[b] <= 0
  - bit b cleared in every snap and in out_branch_mask.
- flush on tag b:
  - cur_mask <= snap[b]
  - tag_free |= cur_mask & ~snap[b] (frees b and all younger tags)
  - out_valid <= 0 if out_branch_mask[b] or (out_is_branch & out_br_tag == b).
- A tag freed this cycle is not allocatable until the next cycle.

## Timing
- Reset values:
  - out_valid=0, cur_mask=0, tag_free=all 1, snap=0.
  - in_ready reflects rob_ready with no flush.
  - rob_alloc=0.
  - Data outputs are don't-care.
- Latency: accept in cycle N gives out_valid in cycle N+1. The reservation station enqueues in the first cycle with out_valid & !resv_full.
- Full throughput: back-to-back accepts with resv_full=0.
- Full condition: out_valid & resv_full forces in_ready=0. The entry register holds, but its mask still updates on good/flush.
- Out of tags: a branch stalls while non-branches proceed.
- Simultaneous accept and good: the new entry's mask already has the bit cleared.
- Simultaneous accept and flush: impossible, since in_ready=0.
- Reset during a stall discards the held entry.

## Structure
- Put BR_TAGS, BRU_BITS and PREG_W in the shared ooo_config package. The entry fields mirror the existing reservation entry typedef.
- Sub-module br_tag_alloc holds cur_mask, snap and tag_free. It exposes alloc, tag and current mask, and takes good/flush inputs.

## Test plan
- Reset, then three non-branch ops with resv_full=0 -> out_valid one cycle after each; out_branch_mask=0000; rob_alloc pulses 3 times.
- Four branches, then a fifth -> tags 0,1,2,3; fifth waits with in_ready=0. After good on tag 1, the fifth gets tag 1 one cycle later.
- Branches get tags 0 then 1, then a load -> load mask 0011. Mispredict tag 0 -> held load dropped, cur_mask=0000, tag_free=1111.
- resv_full=1 with an entry held, then good on tag 2 -> out_branch_mask bit 2 cleared while held; entry drains when resv_full falls.
- Non-branch in_valid while rob_ready=0 -> in_ready=0, rob_alloc=0, entry register unchanged.
- in_valid coincident with a mispredict -> not accepted, and accepted the following cycle with the restored mask.
